flex_pts_tx: RTL and testbench
==============================

// Module: flex_pts_tx
// PURPOSE
//  Parametrised parallel-to-serial transmitter; next generation of the flex PTS shift register.
//  - Adds a valid/ready input handshake and a one-word holding buffer.
//  - Adds an internal bit counter, a per-word runtime bit order and a word-done pulse.
//  - Upstream logic pushes words; a bit-rate enable (shift_strobe) drives serial output.
//  - Back-to-back words are sent with no idle bit between them.
// PARAMETERS
//  NUM_BITS    8   word width; legal range 2..32
//  IDLE_LEVEL  1   serial_out value when no word is being shifted
// PORTS
//  clk           in   1         system clock, rising edge
//  n_rst         in   1         asynchronous, active-low reset
//  data_in       in   NUM_BITS  parallel word; sampled on accept
//  data_valid    in   1         upstream has a word on data_in
//  data_ready    out  1         holding buffer empty; word accepted when valid&&ready
//  msb_first     in   1         1: MSB first, 0: LSB first; sampled when a word enters shifter
//  shift_strobe  in   1         one-cycle bit-rate enable; advances one bit
//  serial_out    out  1         serial data
//  busy          out  1         shifter holds a word (state SHIFT)
//  word_done     out  1         1-cycle pulse after last bit of a word is strobed out
// BEHAVIOUR
//  Reset values
//  - Clock is clk; reset is asynchronous and active-low on n_rst.
//  - On reset: buffer empty, data_ready=1, state IDLE, busy=0, word_done=0.
//  - On reset: serial_out=IDLE_LEVEL, bit count=0.
//  Input handshake
//  - data_ready = !buf_full. It is a registered flag with no combinational path from inputs.
//  - Accept (valid&&ready) writes data_in to the buffer and sets buf_full next edge.
//  - data_valid while ready=0 is ignored; upstream holds its word.
//  States IDLE, SHIFT
//  - IDLE -> SHIFT on any edge with buf_full=1 (transfer).
//    Transfer loads the shifter from the buffer, latches msb_first, clears count and buf_full.
//    Latency: accept edge N, transfer edge N+1, first bit on serial_out after edge N+1.
//  - SHIFT: serial_out = MSB or LSB of the shifter, per the latched order.
//    Each shift_strobe shifts one place (zero fill) and increments the count.
//  - Last strobe, i.e. count == NUM_BITS-1 when strobed, ends the word:
//    - word_done=1 for the next cycle.
//    - If buf_full=1: transfer in the same edge and stay in SHIFT (no gap bit).
//    - Otherwise go to IDLE with serial_out=IDLE_LEVEL.
//  - shift_strobe in IDLE is ignored and does not modify the count.
//  Widths and holds
//  - Count width is $clog2(NUM_BITS); the count never reaches NUM_BITS.
//  - msb_first changes mid-word have no effect on the current word.
//  - Without strobes, serial_out holds indefinitely.
//  Simultaneous events
//  - Accept and transfer on the same edge cannot occur, because ready=0 whenever buf_full=1.
//  - Accept on the same edge as a final strobe with buffer empty: goes to IDLE for one cycle.
//    The transfer follows on the next edge.
//  - Reset mid-word aborts immediately; the shifter and buffer contents are discarded.
// STRUCTURE
//  - Package flex_pts_pkg: typedef enum logic {IDLE, SHIFT} pts_state_t;
//    also the helper function bit_count_w(n) = $clog2(n).
//  - One sub-module: pts_bit_counter.
//    Parametrised width, synchronous clear, enable, and a terminal flag at NUM_BITS-1.
//  - Top level holds the buffer, the shifter, the FSM and the output registers.
// TESTING  (NUM_BITS=8, IDLE_LEVEL=1)
//  1. Reset mid-word, n_rst low at any phase, async:
//     -> serial_out=1, ready=1, busy=0, word_done=0 within the same cycle.
//  2. Push 8'hA5 with msb_first=1, then 8 strobes:
//     -> serial_out sequence 1,0,1,0,0,1,0,1.
//     -> word_done pulses 1 cycle after the 8th strobe; then busy=0 and serial_out=1.
//  3. Push 8'hA5 with msb_first=0:
//     -> sequence 1,0,1,0,0,1,0,1 LSB first, i.e. bits 0..7.
//     Push 8'h01 with msb_first=0 -> 1,0,0,0,0,0,0,0.
//  4. Back-to-back: push 8'hF0, then push 8'h0F while the first is shifting:
//     -> ready=0 after the second accept.
//     -> 16 strobes give 11110000 00001111 with no idle bit between them.
//     -> word_done pulses twice.
//  5. Back-pressure: hold data_valid=1 with three distinct words:
//     -> exactly one accept per free buffer slot; no word dropped or duplicated.
//  6. Strobes in IDLE, and msb_first toggled mid-word:
//     -> no serial_out change in IDLE; the bit order of the current word is unchanged.

Source files
------------

// File: rtl/flex_pts_pkg.sv
// Shared types and helpers for the flex parallel-to-serial transmitter family.
package flex_pts_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pts_state_t;

    // Width of a counter that has to index every bit of an n-bit word.
    function automatic int bit_count_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pts_bit_counter.sv
// Bit position counter for the PTS shifter.
// Raises terminal while the count sits on the last bit of a word.
module pts_bit_counter
    import flex_pts_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = bit_count_w(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    logic [CNT_W-1:0] count;

    // Clear wins over enable so a word boundary always restarts at bit zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST_BIT);

endmodule

// File: rtl/flex_pts_tx.sv
// Parallel-to-serial transmitter with a valid/ready input, a one-word
// holding buffer and gapless back-to-back word transmission.
module flex_pts_tx
    import flex_pts_pkg::*;
#(
    parameter int   NUM_BITS   = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic                msb_first,
    input  logic                shift_strobe,
    output logic                serial_out,
    output logic                busy,
    output logic                word_done
);

    localparam logic ST_IDLE  = logic'(IDLE);
    localparam logic ST_SHIFT = logic'(SHIFT);

    logic                state;
    logic                buf_full;
    logic [NUM_BITS-1:0] buf_data;
    logic [NUM_BITS-1:0] shifter;
    logic                order_msb;
    logic                last_bit;
    logic                accept;
    logic                strobe_shift;
    logic                last_strobe;
    logic                transfer;

    // The buffer can only be written while empty, so accept and transfer never collide.
    assign accept       = data_valid && !buf_full;
    assign strobe_shift = (state == ST_SHIFT) && shift_strobe;
    assign last_strobe  = strobe_shift && last_bit;
    assign transfer     = buf_full && ((state == ST_IDLE) || last_strobe);

    pts_bit_counter #(
        .NUM_BITS (NUM_BITS)
    ) u_bit_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (transfer || last_strobe),
        .enable   (strobe_shift),
        .terminal (last_bit)
    );

    // Holding buffer: filled on accept, emptied when the shifter takes the word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (transfer) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= data_in;
        end
    end

    // FSM and shifter; a final strobe with a full buffer reloads in the same edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            shifter   <= '0;
            order_msb <= 1'b1;
        end else if (transfer) begin
            state     <= ST_SHIFT;
            shifter   <= buf_data;
            order_msb <= msb_first;
        end else if (last_strobe) begin
            state     <= ST_IDLE;
            shifter   <= '0;
        end else if (strobe_shift) begin
            if (order_msb) begin
                shifter <= {shifter[NUM_BITS-2:0], 1'b0};
            end else begin
                shifter <= {1'b0, shifter[NUM_BITS-1:1]};
            end
        end
    end

    // Word-done pulse follows the strobe that pushed out the last bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_done <= 1'b0;
        end else begin
            word_done <= last_strobe;
        end
    end

    assign data_ready = !buf_full;
    assign busy       = (state == ST_SHIFT);
    assign serial_out = (state == ST_SHIFT)
                        ? (order_msb ? shifter[NUM_BITS-1] : shifter[0])
                        : IDLE_LEVEL;

endmodule

// File: tb/tb_flex_pts_tx.sv
// Self-checking bench for flex_pts_tx (NUM_BITS=8, IDLE_LEVEL=1).
// Expected serial bits come from a queue filled from each pushed word.
module tb_flex_pts_tx;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [N-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         msb_first;
    logic         shift_strobe;
    logic         serial_out;
    logic         busy;
    logic         word_done;

    int tests = 0;
    int fails = 0;
    int strobes_done = 0;
    int done_seen = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    flex_pts_tx #(
        .NUM_BITS   (N),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .msb_first    (msb_first),
        .shift_strobe (shift_strobe),
        .serial_out   (serial_out),
        .busy         (busy),
        .word_done    (word_done)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of the serial stream for word w under the chosen order.
    function automatic bit word_bit(input logic [N-1:0] w, input bit msb, input int i);
        return msb ? w[N-1-i] : w[i];
    endfunction

    // Push one word through the handshake and queue its expected bit stream.
    task automatic applyStimulus(input logic [N-1:0] w, input bit msb);
        int guard = 0;
        while (!data_ready && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("ready_wait", data_ready, 1);
        data_in    = w;
        msb_first  = msb;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < N; i++) exp_bits.push_back(word_bit(w, msb, i));
    endtask

    // Strobe n bits, checking each bit before it leaves and the word-done pulse after.
    task automatic shift_bits(input int n);
        bit e;
        for (int k = 0; k < n; k++) begin
            e = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b1;
            checkOutput("serial_bit", serial_out, e);
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            strobes_done++;
            checkOutput("word_done", word_done, (strobes_done % N == 0));
            if (word_done) done_seen++;
        end
    endtask

    // Assert reset between edges and check the idle outputs appear immediately.
    task automatic reset_pulse(input string tag);
        #2 n_rst = 1'b0;
        #1;
        checkOutput({tag, "_serial"}, serial_out, 1);
        checkOutput({tag, "_ready"}, data_ready, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, word_done, 0);
        #2 n_rst = 1'b1;
        exp_bits.delete();
    endtask

    logic [N-1:0] bp_words [3];
    logic [N-1:0] w;
    bit           m;
    bit           bp_acc;
    bit           bp_busy;
    int           idx;
    int           done0;
    int           guard;

    initial begin
        n_rst        = 1'b0;
        data_in      = '0;
        data_valid   = 1'b0;
        msb_first    = 1'b1;
        shift_strobe = 1'b0;
        #2;
        checkOutput("rst_serial", serial_out, 1);
        checkOutput("rst_ready", data_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", word_done, 0);
        #10 n_rst = 1'b1;
        tick();

        // A5 MSB first, then idle level afterwards
        strobes_done = 0;
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_ready_full", data_ready, 0);
        checkOutput("a5_busy_pre", busy, 0);
        tick();
        checkOutput("a5_busy", busy, 1);
        checkOutput("a5_ready_free", data_ready, 1);
        shift_bits(N);
        checkOutput("a5_busy_end", busy, 0);
        checkOutput("a5_idle_level", serial_out, 1);
        tick();
        checkOutput("a5_done_clear", word_done, 0);

        // LSB first words
        strobes_done = 0;
        applyStimulus(8'hA5, 1'b0);
        tick();
        shift_bits(N);
        applyStimulus(8'h01, 1'b0);
        tick();
        shift_bits(N);
        checkOutput("lsb_idle_level", serial_out, 1);

        // Back-to-back words with no gap bit
        strobes_done = 0;
        done0 = done_seen;
        applyStimulus(8'hF0, 1'b1);
        tick();
        shift_bits(1);
        applyStimulus(8'h0F, 1'b1);
        checkOutput("b2b_ready_low", data_ready, 0);
        shift_bits(N - 1);
        checkOutput("b2b_busy_mid", busy, 1);
        checkOutput("b2b_ready_free", data_ready, 1);
        shift_bits(N);
        checkOutput("b2b_busy_end", busy, 0);
        checkOutput("b2b_done_count", done_seen - done0, 2);

        // Back-pressure: valid held high over three distinct words
        bp_words[0] = 8'($urandom);
        do bp_words[1] = 8'($urandom); while (bp_words[1] == bp_words[0]);
        do bp_words[2] = 8'($urandom); while (bp_words[2] == bp_words[0] || bp_words[2] == bp_words[1]);
        m            = 1'($urandom);
        msb_first    = m;
        idx          = 0;
        data_in      = bp_words[0];
        data_valid   = 1'b1;
        shift_strobe = 1'b1;
        strobes_done = 0;
        done0        = done_seen;
        guard        = 0;
        while (!(idx == 3 && exp_bits.size() == 0 && !busy) && guard < 200) begin
            bp_acc  = data_valid && data_ready;
            bp_busy = busy;
            if (bp_busy && exp_bits.size() > 0) checkOutput("bp_bit", serial_out, exp_bits.pop_front());
            else if (bp_busy) checkOutput("bp_extra_bit", busy, 0);
            tick();
            if (bp_busy) strobes_done++;
            if (word_done) done_seen++;
            if (bp_acc) begin
                for (int i = 0; i < N; i++) exp_bits.push_back(word_bit(bp_words[idx], m, i));
                idx++;
                if (idx == 3) data_valid = 1'b0;
                else data_in = bp_words[idx];
            end
            guard++;
        end
        shift_strobe = 1'b0;
        checkOutput("bp_timeout", guard < 200, 1);
        checkOutput("bp_accepts", idx, 3);
        checkOutput("bp_leftover", exp_bits.size(), 0);
        checkOutput("bp_bits", strobes_done, 3 * N);
        checkOutput("bp_done_count", done_seen - done0, 3);
        tick();

        // Strobes in IDLE are ignored
        shift_strobe = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("idle_strobe_serial", serial_out, 1);
            checkOutput("idle_strobe_busy", busy, 0);
        end
        shift_strobe = 1'b0;

        // msb_first toggled mid-word keeps the latched order
        strobes_done = 0;
        applyStimulus(8'hC5, 1'b1);
        tick();
        for (int k = 0; k < N; k++) begin
            msb_first = ~msb_first;
            shift_bits(1);
        end
        checkOutput("toggle_busy_end", busy, 0);

        // Random words, random order, random strobe spacing
        for (int t = 0; t < 12; t++) begin
            w = 8'($urandom);
            m = 1'($urandom);
            strobes_done = 0;
            applyStimulus(w, m);
            tick();
            guard = 0;
            while (exp_bits.size() > 0 && guard < 100) begin
                if ($urandom_range(0, 2) == 0) begin
                    checkOutput("rnd_hold", serial_out, exp_bits[0]);
                    tick();
                    checkOutput("rnd_hold_done", word_done, 0);
                end else begin
                    shift_bits(1);
                end
                guard++;
            end
            checkOutput("rnd_timeout", guard < 100, 1);
            checkOutput("rnd_busy_end", busy, 0);
        end

        // Reset mid-word with a full holding buffer
        strobes_done = 0;
        applyStimulus(8'h96, 1'b1);
        tick();
        shift_bits(3);
        applyStimulus(8'h3C, 1'b0);
        checkOutput("mid_ready_full", data_ready, 0);
        reset_pulse("rst_mid");
        tick();
        checkOutput("rst_mid_no_transfer", busy, 0);
        checkOutput("rst_mid_serial_after", serial_out, 1);

        // Reset while word_done is high
        strobes_done = 0;
        applyStimulus(8'h5A, 1'b0);
        tick();
        shift_bits(N);
        reset_pulse("rst_done_phase");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
